score_bcd_counter: RTL

Four-digit BCD score accumulator that feeds the seven-segment VGA digit painter. It accepts point increments over a valid/ready handshake and adds them serially, one BCD digit per cycle. It also keeps a high-score record and presents one selected digit per request as a 4-bit digit code, plus the record flag. Its `num` and `max` outputs connect directly to the painter's `num` and `max` inputs.

---
 rtl/score_bcd_counter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/score_bcd_counter.sv
// score_bcd_counter
//
// Four-digit BCD score accumulator for the seven-segment VGA digit painter.
// Point increments arrive over a valid/ready handshake. They are added to the
// score one BCD digit per clock, ones digit first, and the result is committed
// in a single step. The block also keeps a high-score record, raises a
// "current score is the record" flag, and serves one selected digit per
// request as a 4-bit painter code.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   : digits 3..1 read as code 11 (blank) when that digit and every
//               digit above it are zero. Digit 0 is never blanked.
//   undefined : zeros read as 0, and code 11 is never produced.
//
// Parameters
//   DIGITS      number of BCD digits held (this block supports only 4)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   add_valid   an increment is offered
//   add_amt     points to add, 0..9 (values above 9 are treated as 9)
//   add_ready   increment can be accepted (idle and no clear requested)
//   game_clear  clear the current score; the high score is kept
//   digit_sel   digit requested by the renderer, 0 = ones .. 3 = thousands
//   num         registered digit code for the painter (0..9, 11 = blank)
//   max         registered flag: current score equals a non-zero record
//   score_bcd   committed score, ones digit in [3:0]
//   high_bcd    committed high score, same packing

module score_bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  add_valid,
  input  logic [3:0]            add_amt,
  output logic                  add_ready,
  input  logic                  game_clear,
  input  logic [1:0]            digit_sel,
  output logic [3:0]            num,
  output logic                  max,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ADD    = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [1:0] LAST_DIGIT = 2'(DIGITS - 1);

  logic [1:0]          state;
  logic [1:0]          digit_idx;
  logic [3:0]          carry;
  logic                ovf;
  logic [4*DIGITS-1:0] work;

  logic [3:0]          amt_clamped;
  logic [3:0]          cur_digit;
  logic [4:0]          digit_sum;
  logic                sum_wrap;
  logic [3:0]          digit_new;
  logic [4*DIGITS-1:0] commit_value;
  logic                high_update;
  logic [3:0]          num_next;

  // The block only takes new work when idle. A pending clear blocks the
  // handshake, so an add and a clear can never be accepted on the same edge.
  assign add_ready = (state == IDLE) && !game_clear;

  // Clamp out-of-range amounts to the largest single BCD digit.
  assign amt_clamped = (add_amt > 4'd9) ? 4'd9 : add_amt;

  // Serial digit adder. At digit 0 the carry register holds the whole
  // amount (up to 9). At every later digit it holds only the 0/1 carry.
  // The sum of the two is at most 18.
  assign cur_digit = work[{digit_idx, 2'b00} +: 4];
  assign digit_sum = {1'b0, cur_digit} + {1'b0, carry};
  assign sum_wrap  = digit_sum > 5'd9;

  // Subtracting 10 is the same as adding 6 modulo 16 for sums in 10..18.
  // This keeps the correction 4 bits wide.
  assign digit_new = sum_wrap ? (digit_sum[3:0] + 4'd6) : digit_sum[3:0];

  // Overflow out of the top digit saturates the score at all nines.
  assign commit_value = ovf ? {DIGITS{4'h9}} : work;

  // With valid BCD packing, binary magnitude order matches decimal order.
  // A plain compare is therefore enough.
  assign high_update = commit_value >= high_bcd;

  // Digit selection for the painter, optionally with leading-zero blanking.
  // Shifting the selected digit down to bit 0 leaves exactly "this digit and
  // everything above it". If that remainder is zero, the position is a
  // leading zero.
`ifdef LEADING_ZERO_BLANK_EN
  logic [4*DIGITS-1:0] upper_digits;

  always_comb begin
    upper_digits = score_bcd >> {digit_sel, 2'b00};
    num_next     = score_bcd[{digit_sel, 2'b00} +: 4];
    if ((digit_sel != 2'd0) && (upper_digits == '0)) begin
      num_next = 4'd11;
    end
  end
`else
  always_comb begin
    num_next = score_bcd[{digit_sel, 2'b00} +: 4];
  end
`endif

  // Sequencer: IDLE accepts an increment and snapshots the committed score
  // into the working register. ADD walks the four digits, ones first, and
  // moves the carry upward. COMMIT is one cycle in which the score registers
  // take the result. A clear overrides everything and drops any add in
  // flight, so a partial sum is never committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      digit_idx <= 2'd0;
      carry     <= 4'd0;
      ovf       <= 1'b0;
      work      <= '0;
    end else if (game_clear) begin
      state     <= IDLE;
      digit_idx <= 2'd0;
      carry     <= 4'd0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (add_valid) begin
            carry     <= amt_clamped;
            work      <= score_bcd;
            digit_idx <= 2'd0;
            ovf       <= 1'b0;
            state     <= ADD;
          end
        end
        ADD: begin
          work[{digit_idx, 2'b00} +: 4] <= digit_new;
          carry <= {3'b000, sum_wrap};
          if (digit_idx == LAST_DIGIT) begin
            ovf   <= sum_wrap;
            state <= COMMIT;
          end else begin
            digit_idx <= digit_idx + 2'd1;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Committed score and high score. These change only in COMMIT or on a
  // clear, so working values from the adder never reach the outputs. A clear
  // zeroes the score but deliberately leaves the record alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_bcd <= '0;
      high_bcd  <= '0;
    end else if (game_clear) begin
      score_bcd <= '0;
    end else if (state == COMMIT) begin
      score_bcd <= commit_value;
      if (high_update) begin
        high_bcd <= commit_value;
      end
    end
  end

  // Painter-facing outputs are registered. The record flag therefore trails
  // a score change by one cycle, and the digit code trails both digit_sel
  // and score changes by one cycle. A record of zero does not count, so a
  // fresh game does not light the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num <= 4'd0;
      max <= 1'b0;
    end else begin
      num <= num_next;
      max <= (score_bcd == high_bcd) && (high_bcd != '0);
    end
  end

endmodule
